conn_manager: RTL

CONN_MANAGER -- requirements
Module: conn_manager

---
 rtl/conn_manager_if.sv | 32 +++
 rtl/conn_manager.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/conn_manager_if.sv
// Control-plane bundle for conn_manager: user requests/responses, outgoing
// control packets, received peer packets and the published state stream.
interface conn_manager_if;
    logic        Req_Connect;
    logic        Req_Close;
    logic [31:0] INIT_SEQ;
    logic        Res_Connect;
    logic        conn_ok;
    logic        Res_Close;
    logic        close_ok;
    logic        hs_valid;
    logic        hs_ready;
    logic [1:0]  hs_type;
    logic [31:0] hs_seq;
    logic        peer_valid;
    logic [1:0]  peer_type;
    logic [31:0] udt_state;
    logic        state_valid;
    logic        state_ready;

    modport slave (
        input  Req_Connect, Req_Close, INIT_SEQ, hs_ready, peer_valid, peer_type, state_ready,
        output Res_Connect, conn_ok, Res_Close, close_ok, hs_valid, hs_type, hs_seq,
               udt_state, state_valid
    );

    modport master (
        output Req_Connect, Req_Close, INIT_SEQ, hs_ready, peer_valid, peer_type, state_ready,
        input  Res_Connect, conn_ok, Res_Close, close_ok, hs_valid, hs_type, hs_seq,
               udt_state, state_valid
    );
endinterface

// File: rtl/conn_manager.sv
// Connection lifecycle controller: handshake with bounded retries, orderly close,
// peer shutdown handling, and a latest-wins published state stream.
module conn_manager #(
    parameter int unsigned RETRY_CYCLES = 100000,
    parameter int unsigned MAX_RETRY    = 4,
    parameter logic [31:0] INIT_STATE   = 32'h0,
    parameter logic [31:0] CONNECTING   = 32'h1,
    parameter logic [31:0] CONNECTED    = 32'h10,
    parameter logic [31:0] CLOSING      = 32'h100,
    parameter logic [31:0] CLOSED       = 32'h1000
) (
    input  logic          ctrl_s_axi_aclk,
    input  logic          ctrl_s_axi_aresetn,
    conn_manager_if.slave ctrl
);

    typedef enum logic [2:0] {
        IDLE, CONN_SEND, CONN_WAIT, ESTAB, CLOSE_SEND, CLOSE_WAIT, DOWN
    } state_t;

    localparam logic [31:0] TIMER_LAST = 32'(RETRY_CYCLES - 1);
    localparam logic [7:0]  RETRY_LAST = 8'(MAX_RETRY - 1);
    localparam logic [1:0]  PKT_HS     = 2'b01;
    localparam logic [1:0]  PKT_SHUT   = 2'b10;

    state_t      state_reg, state_next;
    logic [31:0] timer_reg, timer_next;
    logic [7:0]  retry_reg, retry_next;
    logic        hs_valid_reg, hs_valid_next;
    logic [1:0]  hs_type_reg, hs_type_next;
    logic [31:0] hs_seq_reg, hs_seq_next;
    logic        res_connect_reg, res_connect_next;
    logic        conn_ok_reg, conn_ok_next;
    logic        res_close_reg, res_close_next;
    logic        close_ok_reg, close_ok_next;
    logic [31:0] udt_state_reg;
    logic        state_valid_reg;
    logic        peer_hs, peer_shut;
    logic [31:0] code_next;
    logic        publish;

    function automatic logic [31:0] code_of(input state_t s);
        case (s)
            CONN_SEND, CONN_WAIT:   code_of = CONNECTING;
            ESTAB:                  code_of = CONNECTED;
            CLOSE_SEND, CLOSE_WAIT: code_of = CLOSING;
            DOWN:                   code_of = CLOSED;
            default:                code_of = INIT_STATE;
        endcase
    endfunction

    assign peer_hs   = ctrl.peer_valid && (ctrl.peer_type == PKT_HS);
    assign peer_shut = ctrl.peer_valid && (ctrl.peer_type == PKT_SHUT);

    always_comb begin
        state_next       = state_reg;
        timer_next       = timer_reg;
        retry_next       = retry_reg;
        hs_valid_next    = hs_valid_reg;
        hs_type_next     = hs_type_reg;
        hs_seq_next      = hs_seq_reg;
        res_connect_next = 1'b0;
        conn_ok_next     = 1'b0;
        res_close_next   = 1'b0;
        close_ok_next    = 1'b0;

        case (state_reg)
            IDLE, DOWN: begin
                if (ctrl.Req_Connect) begin
                    state_next    = CONN_SEND;
                    hs_seq_next   = ctrl.INIT_SEQ;
                    hs_valid_next = 1'b1;
                    hs_type_next  = PKT_HS;
                    retry_next    = '0;
                    timer_next    = '0;
                end
            end
            CONN_SEND: begin
                if (ctrl.hs_ready) begin
                    state_next    = CONN_WAIT;
                    hs_valid_next = 1'b0;
                    timer_next    = '0;
                end
            end
            CONN_WAIT: begin
                // A response in the expiry cycle still counts as success.
                if (peer_hs) begin
                    state_next       = ESTAB;
                    res_connect_next = 1'b1;
                    conn_ok_next     = 1'b1;
                end else if (timer_reg == TIMER_LAST) begin
                    if (retry_reg == RETRY_LAST) begin
                        state_next       = DOWN;
                        res_connect_next = 1'b1;
                    end else begin
                        state_next    = CONN_SEND;
                        retry_next    = retry_reg + 8'd1;
                        hs_valid_next = 1'b1;
                        hs_type_next  = PKT_HS;
                        timer_next    = '0;
                    end
                end else begin
                    timer_next = timer_reg + 32'd1;
                end
            end
            ESTAB: begin
                if (ctrl.Req_Close) begin
                    state_next    = CLOSE_SEND;
                    hs_valid_next = 1'b1;
                    hs_type_next  = PKT_SHUT;
                end else if (peer_shut) begin
                    state_next = DOWN;
                end
            end
            CLOSE_SEND: begin
                if (ctrl.hs_ready) begin
                    state_next    = CLOSE_WAIT;
                    hs_valid_next = 1'b0;
                    timer_next    = '0;
                end
            end
            CLOSE_WAIT: begin
                if (peer_shut || (timer_reg == TIMER_LAST)) begin
                    state_next     = DOWN;
                    res_close_next = 1'b1;
                    close_ok_next  = 1'b1;
                end else begin
                    timer_next = timer_reg + 32'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Misplaced requests are refused; a completion in the same cycle takes the pulse.
        if (ctrl.Req_Connect && (state_reg != IDLE) && (state_reg != DOWN) && !res_connect_next)
            res_connect_next = 1'b1;
        if (ctrl.Req_Close && (state_reg != ESTAB) && !res_close_next)
            res_close_next = 1'b1;
    end

    assign code_next = code_of(state_next);
    assign publish   = (code_next != code_of(state_reg));

    always_ff @(posedge ctrl_s_axi_aclk or negedge ctrl_s_axi_aresetn) begin
        if (!ctrl_s_axi_aresetn) begin
            state_reg       <= IDLE;
            timer_reg       <= '0;
            retry_reg       <= '0;
            hs_valid_reg    <= 1'b0;
            hs_type_reg     <= '0;
            hs_seq_reg      <= '0;
            res_connect_reg <= 1'b0;
            conn_ok_reg     <= 1'b0;
            res_close_reg   <= 1'b0;
            close_ok_reg    <= 1'b0;
            udt_state_reg   <= INIT_STATE;
            state_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            retry_reg       <= retry_next;
            hs_valid_reg    <= hs_valid_next;
            hs_type_reg     <= hs_type_next;
            hs_seq_reg      <= hs_seq_next;
            res_connect_reg <= res_connect_next;
            conn_ok_reg     <= conn_ok_next;
            res_close_reg   <= res_close_next;
            close_ok_reg    <= close_ok_next;
            if (publish) begin
                udt_state_reg   <= code_next;
                state_valid_reg <= 1'b1;
            end else if (ctrl.state_ready) begin
                state_valid_reg <= 1'b0;
            end
        end
    end

    assign ctrl.hs_valid    = hs_valid_reg;
    assign ctrl.hs_type     = hs_type_reg;
    assign ctrl.hs_seq      = hs_seq_reg;
    assign ctrl.Res_Connect = res_connect_reg;
    assign ctrl.conn_ok     = conn_ok_reg;
    assign ctrl.Res_Close   = res_close_reg;
    assign ctrl.close_ok    = close_ok_reg;
    assign ctrl.udt_state   = udt_state_reg;
    assign ctrl.state_valid = state_valid_reg;

endmodule
